// File: rtl/des_key_schedule.sv
// des_key_schedule
//   Produces the sixteen 48-bit DES round subkeys from a 64-bit key, one per
//   valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
//   DES bit numbering: key bit i is key_in[65-i], subkey bit i is subkey[49-i],
//   so subkey[48:43] is the 6-bit slice that meets sbox1.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     start, decrypt  schedule request and order select (sampled in IDLE)
//     key_in[64:1]    DES key (parity bits unused unless checking is enabled)
//     busy            schedule in progress
//     subkey_valid    subkey / key_idx valid
//     subkey_ready    consumer accepts the current subkey
//     subkey[48:1]    round subkey
//     key_idx[3:0]    index n of K_n on subkey, 16 encoded as 0
//     done            one-cycle pulse after the 16th handshake
//     parity_err      one-cycle pulse after a start with a bad-parity key
//
//   Parameter SUBKEY_REG: 0 = PC-2 combinational from C/D,
//                         1 = registered PC-2 of next C/D (same port timing).
//   Macro DES_KEY_PARITY_EN: when defined, start is refused unless every key
//   byte has odd parity; otherwise parity_err is tied low.

module des_key_schedule #(
  parameter int SUBKEY_REG = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [64:1] key_in,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [48:1] subkey,
  output logic [3:0]  key_idx,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {IDLE, GEN} state_t;

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // {C,D} is held as [55:0] with DES C/D bit j at position 56-j.
  function automatic logic [55:0] pc1(input logic [64:1] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[65-PC1_TAB[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2_TAB[i]];
    return r;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one; every other round by two.
  function automatic logic two_shift(input logic [4:0] round);
    return !(round == 5'd1 || round == 5'd2 || round == 5'd9 || round == 5'd16);
  endfunction

  state_t      state;
  logic [27:0] c, d, c_nx, d_nx;
  logic [4:0]  count;
  logic        dec_q;
  logic [55:0] pc1_key;
  logic        parity_ok, load, hs, last;

`ifdef DES_KEY_PARITY_EN
  logic parity_err_q;

  assign parity_ok = (^key_in[64:57]) & (^key_in[56:49]) & (^key_in[48:41]) &
                     (^key_in[40:33]) & (^key_in[32:25]) & (^key_in[24:17]) &
                     (^key_in[16:9])  & (^key_in[8:1]);

  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= (state == IDLE) && start && !parity_ok;
  end

  assign parity_err = parity_err_q;
`else
  logic unused_parity_bits;

  assign unused_parity_bits = ^{key_in[57], key_in[49], key_in[41], key_in[33],
                                key_in[25], key_in[17], key_in[9],  key_in[1]};
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign pc1_key = pc1(key_in);
  assign load    = (state == IDLE) && start && parity_ok;
  assign hs      = (state == GEN) && subkey_valid && subkey_ready;
  assign last    = (count == 5'd16);

  // Encrypt loads C1/D1 directly; decrypt loads C0/D0, which equals C16/D16.
  always_comb begin
    c_nx = c;
    d_nx = d;
    if (load) begin
      if (decrypt) begin
        c_nx = pc1_key[55:28];
        d_nx = pc1_key[27:0];
      end else begin
        c_nx = rotl28(pc1_key[55:28], 1'b0);
        d_nx = rotl28(pc1_key[27:0], 1'b0);
      end
    end else if (hs && !last) begin
      if (dec_q) begin
        c_nx = rotr28(c, two_shift(5'd17 - count));
        d_nx = rotr28(d, two_shift(5'd17 - count));
      end else begin
        c_nx = rotl28(c, two_shift(count + 5'd1));
        d_nx = rotl28(d, two_shift(count + 5'd1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      c            <= '0;
      d            <= '0;
      count        <= '0;
      dec_q        <= 1'b0;
      busy         <= 1'b0;
      subkey_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      c    <= c_nx;
      d    <= d_nx;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            state        <= GEN;
            count        <= 5'd1;
            dec_q        <= decrypt;
            busy         <= 1'b1;
            subkey_valid <= 1'b1;
          end
        end
        GEN: begin
          if (hs) begin
            if (last) begin
              state        <= IDLE;
              busy         <= 1'b0;
              subkey_valid <= 1'b0;
              done         <= 1'b1;
            end else begin
              count <= count + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // (17 - count) mod 16 == (1 - count) mod 16
  assign key_idx = dec_q ? (4'd1 - count[3:0]) : count[3:0];

  generate
    if (SUBKEY_REG != 0) begin : g_subkey_reg
      logic [47:0] subkey_q;
      always_ff @(posedge clk) begin
        if (rst) subkey_q <= '0;
        else     subkey_q <= pc2({c_nx, d_nx});
      end
      assign subkey = subkey_q;
    end else begin : g_subkey_comb
      assign subkey = pc2({c, d});
    end
  endgenerate

endmodule

// File: tb/tb_des_key_schedule.sv
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, subkey_ready;
  logic [64:1] key_in;

  logic        busy_a, valid_a, done_a, perr_a;
  logic [48:1] sk_a;
  logic [3:0]  idx_a;
  logic        busy_b, valid_b, done_b, perr_b;
  logic [48:1] sk_b;
  logic [3:0]  idx_b;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] KEY     = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD = 64'h133457799BBCDFF0;

  localparam logic [47:0] KS [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  always #5 clk = ~clk;

  des_key_schedule #(.SUBKEY_REG(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .busy(busy_a), .subkey_valid(valid_a), .subkey_ready(subkey_ready),
    .subkey(sk_a), .key_idx(idx_a), .done(done_a), .parity_err(perr_a)
  );

  des_key_schedule #(.SUBKEY_REG(1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .key_in(key_in),
    .busy(busy_b), .subkey_valid(valid_b), .subkey_ready(subkey_ready),
    .subkey(sk_b), .key_idx(idx_b), .done(done_b), .parity_err(perr_b)
  );

  // Both parameter settings must produce identical port traces every cycle.
  always @(negedge clk) begin
    total++;
    if ({busy_a, valid_a, done_a, perr_a, sk_a, idx_a} !==
        {busy_b, valid_b, done_b, perr_b, sk_b, idx_b}) begin
      bad++;
      $display("FAIL subkey_reg_match t=%0t: reg0 busy=%b v=%b done=%b sk=%h idx=%0d, reg1 busy=%b v=%b done=%b sk=%h idx=%0d",
               $time, busy_a, valid_a, done_a, sk_a, idx_a, busy_b, valid_b, done_b, sk_b, idx_b);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; decrypt = 1'b0; subkey_ready = 1'b1; key_in = KEY;
    cyc();
    cyc();
    @(negedge clk);
    total++;
    if ({busy_a, valid_a, done_a, perr_a, idx_a} !== 8'b0 || sk_a !== 48'h0) begin
      bad++;
      $display("FAIL reset: busy=%b valid=%b done=%b perr=%b idx=%0d sk=%h, want all zero",
               busy_a, valid_a, done_a, perr_a, idx_a, sk_a);
    end
    rst = 1'b0; start = 1'b0;
    cyc();
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b valid=%b want 0 0", busy_a, valid_a);
    end
  endtask

  // chain=1: issue a decrypt start in the done cycle
  task automatic test_encrypt(input bit chain);
    cyc();
    key_in = KEY; decrypt = 1'b0; subkey_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int p = 1; p <= 16; p++) begin
      @(negedge clk);
      total++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || done_a !== 1'b0 ||
          sk_a !== KS[p-1] || idx_a !== 4'(p)) begin
        bad++;
        $display("FAIL enc_k%0d: sk=%h idx=%0d valid=%b busy=%b done=%b, want sk=%h idx=%0d valid=1 busy=1 done=0",
                 p, sk_a, idx_a, valid_a, busy_a, done_a, KS[p-1], 4'(p));
      end
      cyc();
    end
    if (chain) begin
      start = 1'b1; decrypt = 1'b1;
    end
    @(negedge clk);
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0 || sk_a !== KS[15]) begin
      bad++;
      $display("FAIL enc_done: done=%b busy=%b valid=%b sk=%h, want done=1 busy=0 valid=0 sk=%h",
               done_a, busy_a, valid_a, sk_a, KS[15]);
    end
    if (!chain) begin
      cyc();
      @(negedge clk);
      total++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        bad++;
        $display("FAIL enc_done_pulse: done=%b busy=%b want 0 0", done_a, busy_a);
      end
    end
  endtask

  task automatic test_decrypt(input bit started);
    if (!started) begin
      cyc();
      key_in = KEY; decrypt = 1'b1; subkey_ready = 1'b1; start = 1'b1;
    end
    cyc();
    start = 1'b0; decrypt = 1'b0;
    for (int p = 1; p <= 16; p++) begin
      @(negedge clk);
      total++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || sk_a !== KS[16-p] || idx_a !== 4'(17 - p)) begin
        bad++;
        $display("FAIL dec_pos%0d: sk=%h idx=%0d valid=%b busy=%b, want sk=%h idx=%0d valid=1 busy=1",
                 p, sk_a, idx_a, valid_a, busy_a, KS[16-p], 4'(17 - p));
      end
      cyc();
    end
    @(negedge clk);
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0 || sk_a !== KS[0]) begin
      bad++;
      $display("FAIL dec_done: done=%b busy=%b valid=%b sk=%h, want done=1 busy=0 valid=0 sk=%h",
               done_a, busy_a, valid_a, sk_a, KS[0]);
    end
    cyc();
    @(negedge clk);
    total++;
    if (done_a !== 1'b0) begin
      bad++;
      $display("FAIL dec_done_pulse: done=%b want 0", done_a);
    end
  endtask

  task automatic test_stall();
    int p;
    int cycles;
    bit rdy;
    cyc();
    key_in = KEY; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b0;
    cyc();
    p = 1;
    cycles = 0;
    while (p <= 16 && cycles < 300) begin
      rdy = 1'($urandom_range(0, 1));
      subkey_ready = rdy;
      decrypt = 1'($urandom_range(0, 1));
      start = (p == 16 && rdy) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || sk_a !== KS[p-1] || idx_a !== 4'(p)) begin
        bad++;
        $display("FAIL stall_k%0d cyc%0d: sk=%h idx=%0d valid=%b busy=%b, want sk=%h idx=%0d valid=1 busy=1",
                 p, cycles, sk_a, idx_a, valid_a, busy_a, KS[p-1], 4'(p));
      end
      cyc();
      if (rdy) p++;
      cycles++;
    end
    total++;
    if (p <= 16) begin
      bad++;
      $display("FAIL stall_timeout: reached k%0d want 17", p);
    end
    start = 1'b0; subkey_ready = 1'b1;
    @(negedge clk);
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL stall_done: done=%b busy=%b valid=%b want 1 0 0", done_a, busy_a, valid_a);
    end
    cyc();
    @(negedge clk);
    total++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL stall_start_ignored: busy=%b valid=%b done=%b want 0 0 0", busy_a, valid_a, done_a);
    end
  endtask

  task automatic test_rst_mid();
    cyc();
    key_in = KEY; decrypt = 1'b0; subkey_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int p = 1; p < 7; p++) cyc();
    @(negedge clk);
    total++;
    if (sk_a !== KS[6] || idx_a !== 4'd7) begin
      bad++;
      $display("FAIL rst_pre_k7: sk=%h idx=%0d want sk=%h idx=7", sk_a, idx_a, KS[6]);
    end
    rst = 1'b1;
    cyc();
    @(negedge clk);
    total++;
    if ({busy_a, valid_a, done_a, perr_a, idx_a} !== 8'b0 || sk_a !== 48'h0) begin
      bad++;
      $display("FAIL rst_mid: busy=%b valid=%b done=%b perr=%b idx=%0d sk=%h, want all zero",
               busy_a, valid_a, done_a, perr_a, idx_a, sk_a);
    end
    rst = 1'b0;
    cyc();
    @(negedge clk);
    total++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_done: done=%b busy=%b want 0 0", done_a, busy_a);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int p = 1; p <= 2; p++) begin
      @(negedge clk);
      total++;
      if (valid_a !== 1'b1 || sk_a !== KS[p-1] || idx_a !== 4'(p)) begin
        bad++;
        $display("FAIL rst_restart_k%0d: sk=%h idx=%0d valid=%b want sk=%h idx=%0d valid=1",
                 p, sk_a, idx_a, valid_a, KS[p-1], 4'(p));
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_parity();
    cyc();
    key_in = KEY_BAD; decrypt = 1'b0; subkey_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
`ifdef DES_KEY_PARITY_EN
    @(negedge clk);
    total++;
    if (perr_a !== 1'b1 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
      bad++;
      $display("FAIL parity_bad: perr=%b busy=%b valid=%b want 1 0 0", perr_a, busy_a, valid_a);
    end
    cyc();
    @(negedge clk);
    total++;
    if (perr_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL parity_pulse: perr=%b busy=%b want 0 0", perr_a, busy_a);
    end
    key_in = KEY; start = 1'b1;
    cyc();
    start = 1'b0;
    @(negedge clk);
    total++;
    if (perr_a !== 1'b0 || valid_a !== 1'b1 || sk_a !== KS[0]) begin
      bad++;
      $display("FAIL parity_good: perr=%b valid=%b sk=%h want 0 1 %h", perr_a, valid_a, sk_a, KS[0]);
    end
`else
    for (int p = 1; p <= 2; p++) begin
      @(negedge clk);
      total++;
      if (perr_a !== 1'b0 || valid_a !== 1'b1 || sk_a !== KS[p-1] || idx_a !== 4'(p)) begin
        bad++;
        $display("FAIL parity_ignored_k%0d: perr=%b valid=%b sk=%h idx=%0d want 0 1 %h %0d",
                 p, perr_a, valid_a, sk_a, idx_a, KS[p-1], 4'(p));
      end
      cyc();
    end
`endif
    begin
      int n;
      n = 0;
      while (busy_a === 1'b1 && n < 40) begin
        cyc();
        n++;
      end
      total++;
      if (busy_a !== 1'b0) begin
        bad++;
        $display("FAIL parity_drain: busy=%b want 0", busy_a);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; subkey_ready = 1'b0; key_in = '0;
    test_reset();
    test_encrypt(1'b0);
    test_encrypt(1'b1);
    test_decrypt(1'b1);
    test_decrypt(1'b0);
    test_stall();
    test_rst_mid();
    test_parity();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
